sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 169 ++++++++++++++++
 tb/tb_sync_fifo_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock parameterised FIFO with occupancy count, sticky
//               overflow/underflow flags and a selectable read mode
//               (registered read or first-word-fall-through).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        data word width in bits
//   DEPTH        number of entries (power of two, >= 2)
//   FWFT         0 = registered read (1-cycle latency), 1 = first-word-fall-through
//   AF_LEVEL     almost_full asserted when length >= AF_LEVEL
//   AE_LEVEL     almost_empty asserted when length <= AE_LEVEL
// Ports
//   clk          clock, all state changes on rising edge
//   rst          asynchronous reset, active low
//   clear        synchronous flush, active high, highest priority
//   writesig     write request, datain is the write word
//   readsig      read request
//   dataout      read word
//   full/empty   length == DEPTH / length == 0
//   almost_full  length >= AF_LEVEL
//   almost_empty length <= AE_LEVEL
//   length       current occupancy, 0..DEPTH
//   overflow     sticky: a write was rejected because the FIFO was full
//   underflow    sticky: a read was rejected because the FIFO was empty
// ============================================================================
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     writesig,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     readsig,
  output logic [WIDTH-1:0]         dataout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   length,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = c_aw + 1;

  localparam logic [c_lw-1:0] c_depth = c_lw'(DEPTH);
  localparam logic [c_lw-1:0] c_af    = c_lw'(AF_LEVEL);
  localparam logic [c_lw-1:0] c_ae    = c_lw'(AE_LEVEL);
  localparam logic [c_lw-1:0] c_one   = c_lw'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_lw-1:0]  r_len;
  logic             r_ovf;
  logic             r_udf;
  logic [WIDTH-1:0] r_dout;

  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [c_lw-1:0]  w_len_nxt;
  logic [c_aw-1:0]  w_rptr_nxt;

  // Flags are decoded from the registered count so they all move together.
  assign w_empty = (r_len == '0);
  assign w_full  = (r_len == c_depth);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_rd_acc = readsig & ~w_empty;
  assign w_wr_acc = writesig & (~w_full | w_rd_acc);

  // DEPTH is a power of two, so pointer wrap is plain binary rollover.
  assign w_rptr_nxt = w_rd_acc ? (r_rptr + c_aw'(1)) : r_rptr;

  always_comb begin
    w_len_nxt = r_len;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_len_nxt = r_len + c_one;
      2'b01:   w_len_nxt = r_len - c_one;
      default: w_len_nxt = r_len;
    endcase
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_len  <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else if (clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_len  <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + c_aw'(1);
      end
      r_rptr <= w_rptr_nxt;
      r_len  <= w_len_nxt;
      if (writesig && w_full && !w_rd_acc) begin
        r_ovf <= 1'b1;
      end
      if (readsig && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  // Storage array carries no reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (rst && !clear && w_wr_acc) begin
      r_mem[r_wptr] <= datain;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Output register tracks the word that will be at the head after this
      // edge. When the FIFO will hold exactly one word and that word is being
      // written now, it is not yet in the array, so bypass it from datain.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dout <= '0;
        end else if (!clear && (w_len_nxt != '0)) begin
          if (w_wr_acc && (w_len_nxt == c_one)) begin
            r_dout <= datain;
          end else begin
            r_dout <= r_mem[w_rptr_nxt];
          end
        end
      end
    end else begin : g_regrd
      // Registered read: the head word is captured on the accepting edge.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dout <= '0;
        end else if (!clear && w_rd_acc) begin
          r_dout <= r_mem[r_rptr];
        end
      end
    end
  endgenerate

  assign dataout      = r_dout;
  assign length       = r_len;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_len >= c_af);
  assign almost_empty = (r_len <= c_ae);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param. One instance in
//               registered-read mode, one in first-word-fall-through mode,
//               sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

  localparam int c_af = 14;
  localparam int c_ae = 2;

  logic clk;
  logic rst;

  // Registered-read instance signals
  logic       clr0, wr0, rd0;
  logic [7:0] din0, dout0;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic [4:0] len0;

  // FWFT instance signals
  logic       clr1, wr1, rd1;
  logic [7:0] din1, dout1;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] len1;

  int n_checks;
  int n_pass;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clr0), .writesig(wr0), .datain(din0),
    .readsig(rd0), .dataout(dout0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .length(len0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clr1), .writesig(wr1), .datain(din1),
    .readsig(rd1), .dataout(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .length(len1),
    .overflow(ovf1), .underflow(udf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare packed {dout, len, full, empty, af, ae, ovf, udf}; flags expected
  // from the expected length against the configured thresholds.
  task automatic cmp(input string name, input logic [18:0] act,
                     input logic [7:0] ed, input int el, input logic eo, input logic eu);
    logic [18:0] exp;
    exp = {ed, 5'(el), (el == 16), (el == 0), (el >= c_af), (el <= c_ae), eo, eu};
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got dout=%h len=%0d f/e/af/ae/ovf/udf=%b, want dout=%h len=%0d f/e/af/ae/ovf/udf=%b",
               name, act[18:11], act[10:6], act[5:0], exp[18:11], exp[10:6], exp[5:0]);
    end
  endtask

  task automatic chk0(input string name, input logic [7:0] ed, input int el,
                      input logic eo, input logic eu);
    cmp({"dut0 ", name}, {dout0, len0, full0, empty0, af0, ae0, ovf0, udf0}, ed, el, eo, eu);
  endtask

  task automatic chk1(input string name, input logic [7:0] ed, input int el,
                      input logic eo, input logic eu);
    cmp({"dut1 ", name}, {dout1, len1, full1, empty1, af1, ae1, ovf1, udf1}, ed, el, eo, eu);
  endtask

  task automatic step0(input logic c, input logic w, input logic r, input logic [7:0] d);
    clr0 = c; wr0 = w; rd0 = r; din0 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic c, input logic w, input logic r, input logic [7:0] d);
    clr1 = c; wr1 = w; rd1 = r; din1 = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       clr;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] edout;
    int         elen;
    logic       eovf;
    logic       eudf;
    string      name;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;

    //              clr   wr    rd    din    dout   len ovf   udf
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1, 1'b0, 1'b0, "wr1"};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 2, 1'b0, 1'b0, "wr2"};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h03, 8'h00, 3, 1'b0, 1'b0, "wr3"};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h04, 8'h00, 4, 1'b0, 1'b0, "wr4"};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 3, 1'b0, 1'b0, "rd1"};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 2, 1'b0, 1'b0, "rd2"};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h03, 1, 1'b0, 1'b0, "rd3"};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 0, 1'b0, 1'b0, "rd4"};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 0, 1'b0, 1'b1, "rd_empty"};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h55, 8'h04, 1, 1'b0, 1'b1, "rdwr_empty"};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h55, 0, 1'b0, 1'b1, "rd_55"};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 0, 1'b0, 1'b0, "clear"};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h77, 8'h55, 0, 1'b0, 1'b0, "clear_ign"};

    clr0 = 0; wr0 = 0; rd0 = 0; din0 = 0;
    clr1 = 0; wr1 = 0; rd1 = 0; din1 = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk0("reset", 8'h00, 0, 1'b0, 1'b0);
    chk1("reset", 8'h00, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic order, underflow, simultaneous read/write while empty, clear.
    for (int i = 0; i < 13; i++) begin
      step0(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk0(vecs[i].name, vecs[i].edout, vecs[i].elen, vecs[i].eovf, vecs[i].eudf);
    end

    // Fill to full, then one rejected write.
    for (int i = 0; i < 16; i++) begin
      step0(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
      chk0($sformatf("fill%0d", i), 8'h55, i + 1, 1'b0, 1'b0);
    end
    step0(1'b0, 1'b1, 1'b0, 8'hEE);
    chk0("overflow", 8'h55, 16, 1'b1, 1'b0);

    // Sustained read+write at full: pointers wrap, order preserved.
    for (int k = 0; k < 20; k++) begin
      step0(1'b0, 1'b1, 1'b1, 8'(8'h20 + k));
      chk0($sformatf("rw%0d", k), 8'(8'h10 + k), 16, 1'b1, 1'b0);
    end

    // Drain: words 0x24..0x33 must come out intact.
    for (int j = 0; j < 16; j++) begin
      step0(1'b0, 1'b0, 1'b1, 8'h00);
      chk0($sformatf("drain%0d", j), 8'(8'h24 + j), 15 - j, 1'b1, 1'b0);
    end

    // Five words with overflow still set, then clear.
    for (int i = 0; i < 5; i++) begin
      step0(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    end
    chk0("five_stored", 8'h33, 5, 1'b1, 1'b0);
    step0(1'b1, 1'b0, 1'b0, 8'h00);
    chk0("clear5", 8'h33, 0, 1'b0, 1'b0);

    // Reset asserted mid-write must act without a clock edge.
    step0(1'b0, 1'b1, 1'b0, 8'h70);
    chk0("pre_rst_wr", 8'h33, 1, 1'b0, 1'b0);
    din0 = 8'h71;
    #2 rst = 1'b0;
    #1;
    chk0("async_rst", 8'h00, 0, 1'b0, 1'b0);
    chk1("async_rst", 8'h00, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    din0 = 8'h99;
    @(posedge clk);
    #1;
    chk0("post_rst_wr", 8'h00, 1, 1'b0, 1'b0);
    step0(1'b0, 1'b0, 1'b1, 8'h00);
    chk0("post_rst_rd", 8'h99, 0, 1'b0, 1'b0);

    // First-word-fall-through behaviour.
    step1(1'b0, 1'b1, 1'b0, 8'hA5);
    chk1("fwft_a5", 8'hA5, 1, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b0, 8'h00);
    chk1("fwft_hold", 8'hA5, 1, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b1, 8'h00);
    chk1("fwft_rd_empty", 8'hA5, 0, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b0, 8'h11);
    chk1("fwft_w11", 8'h11, 1, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b0, 8'h22);
    chk1("fwft_w22", 8'h11, 2, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b0, 8'h33);
    chk1("fwft_w33", 8'h11, 3, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b1, 8'h00);
    chk1("fwft_r22", 8'h22, 2, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b1, 8'h44);
    chk1("fwft_rw33", 8'h33, 2, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b1, 8'h00);
    chk1("fwft_r44", 8'h44, 1, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b1, 8'h88);
    chk1("fwft_rw88_len1", 8'h88, 1, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b1, 8'h00);
    chk1("fwft_r_last", 8'h88, 0, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b1, 8'h00);
    chk1("fwft_underflow", 8'h88, 0, 1'b0, 1'b1);
    step1(1'b0, 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
